// File: rtl/irq_ctrl_8_pkg.sv
// Shared definitions for the 8-source interrupt controller.
// Contains the state encodings, the source count and the default trap vector base.
package irq_ctrl_8_pkg;

    localparam int NUM_IRQ = 8;
    localparam int ID_W    = 3;

    // FSM state encodings (2-bit, legacy-compatible constants)
    localparam logic [1:0] IRQ_IDLE   = 2'd0;
    localparam logic [1:0] IRQ_REQ    = 2'd1;
    localparam logic [1:0] IRQ_ACTIVE = 2'd2;

    localparam logic [31:0] IRQ_VEC_BASE_DEFAULT = 32'h0000_0100;

    // Trap vector for a given id: base + 4*id, wrapping modulo 2^32
    function automatic logic [31:0] trap_vector(input logic [31:0] base,
                                                input logic [ID_W-1:0] id);
        trap_vector = base + {27'd0, id, 2'b00};
    endfunction

endpackage

// File: rtl/irq_ctrl_8_encoder.sv
// 8:3 priority encoder: returns the highest set index of in_vec.
// Output is 0 when no bit is set; callers qualify it with their own 'any'.
module encoder_8
    import irq_ctrl_8_pkg::*;
(
    input  logic [NUM_IRQ-1:0] in_vec,
    output logic [ID_W-1:0]    idx
);

    // Scan upward so the highest set bit overwrites lower ones
    always_comb begin
        idx = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (in_vec[i]) begin
                idx = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/irq_ctrl_8.sv
// 8-source interrupt controller for the rv32i core.
// Captures edge/level sources into a pending register, masks them, and
// presents one request at a time to the core through a req/ack/done handshake.
// No nesting: a new request is only raised after the active one completes.
module irq_ctrl_8
    import irq_ctrl_8_pkg::*;
#(
    parameter logic [31:0]        VEC_BASE  = IRQ_VEC_BASE_DEFAULT,
    parameter logic [NUM_IRQ-1:0] LEVEL_SRC = 8'h00
)
(
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [NUM_IRQ-1:0]  i_irq,
    input  logic                i_mask_we,
    input  logic [NUM_IRQ-1:0]  i_mask_wdata,
    output logic [NUM_IRQ-1:0]  o_mask,
    output logic [NUM_IRQ-1:0]  o_pending,
    output logic                o_irq_req,
    output logic [ID_W-1:0]     o_irq_id,
    output logic [31:0]         o_trap_vec,
    input  logic                i_irq_ack,
    input  logic                i_irq_done,
    output logic                o_busy
);

    logic [NUM_IRQ-1:0] mask_reg;
    logic [NUM_IRQ-1:0] pending_reg;
    logic [NUM_IRQ-1:0] pending_next;
    logic [NUM_IRQ-1:0] irq_d_reg;
    logic [1:0]         state_reg;
    logic [1:0]         state_next;
    logic [ID_W-1:0]    id_reg;
    logic [ID_W-1:0]    id_next;

    logic [NUM_IRQ-1:0] sel;
    logic               any;
    logic [ID_W-1:0]    win;
    logic               ack_fire;
    logic [NUM_IRQ-1:0] ack_clr;
    logic [NUM_IRQ-1:0] rise;

    // Arbitration: only enabled pending sources compete
    assign sel = pending_reg & mask_reg;
    assign any = |sel;

    encoder_8 u_encoder (
        .in_vec (sel),
        .idx    (win)
    );

    // An ack only counts while a request is actually outstanding
    assign ack_fire = (state_reg == IRQ_REQ) && i_irq_ack;
    assign ack_clr  = ack_fire ? (NUM_IRQ'(1) << id_reg) : '0;
    assign rise     = i_irq & ~irq_d_reg;

    // Per-source pending update: level sources mirror the input, edge sources
    // latch a rising edge and are cleared by an ack (a new edge wins over the clear)
    generate
        for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_pending
            if (LEVEL_SRC[gi]) begin : g_level
                assign pending_next[gi] = i_irq[gi];
            end else begin : g_edge
                assign pending_next[gi] = rise[gi] | (pending_reg[gi] & ~ack_clr[gi]);
            end
        end
    endgenerate

    // Source history, pending and mask registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            irq_d_reg   <= '0;
            pending_reg <= '0;
            mask_reg    <= '0;
        end else begin
            irq_d_reg   <= i_irq;
            pending_reg <= pending_next;
            if (i_mask_we) begin
                mask_reg <= i_mask_wdata;
            end
        end
    end

    // Next-state logic: id is locked on entry to REQ and never re-arbitrated
    always_comb begin
        state_next = state_reg;
        id_next    = id_reg;
        case (state_reg)
            IRQ_IDLE: begin
                if (any) begin
                    state_next = IRQ_REQ;
                    id_next    = win;
                end
            end
            IRQ_REQ: begin
                // Ack has priority over the request being withdrawn
                if (i_irq_ack) begin
                    state_next = IRQ_ACTIVE;
                end else if (!sel[id_reg]) begin
                    state_next = IRQ_IDLE;
                end
            end
            IRQ_ACTIVE: begin
                if (i_irq_done) begin
                    state_next = IRQ_IDLE;
                end
            end
            default: begin
                state_next = IRQ_IDLE;
            end
        endcase
    end

    // FSM state and locked id registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg <= IRQ_IDLE;
            id_reg    <= '0;
        end else begin
            state_reg <= state_next;
            id_reg    <= id_next;
        end
    end

    assign o_mask     = mask_reg;
    assign o_pending  = pending_reg;
    assign o_irq_req  = (state_reg == IRQ_REQ);
    assign o_busy     = (state_reg == IRQ_ACTIVE);
    assign o_irq_id   = id_reg;
    assign o_trap_vec = trap_vector(VEC_BASE, id_reg);

endmodule

// File: tb/tb_irq_ctrl_8.sv
// Self-checking bench for irq_ctrl_8. Source 0 is level-sensitive, the rest edge.
// Expected requests are queued when stimulus is driven and compared when
// o_irq_req rises; register/state checks are made directly.
module tb_irq_ctrl_8;

    typedef struct {
        logic [2:0]  id;
        logic [31:0] vec;
    } exp_t;

    logic        clk;
    logic        srst;
    logic [7:0]  irq;
    logic        mask_we;
    logic [7:0]  mask_wdata;
    logic [7:0]  mask;
    logic [7:0]  pending;
    logic        irq_req;
    logic [2:0]  irq_id;
    logic [31:0] trap_vec;
    logic        irq_ack;
    logic        irq_done;
    logic        busy;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    logic req_prev = 1'b0;

    irq_ctrl_8 #(
        .VEC_BASE  (32'h0000_0100),
        .LEVEL_SRC (8'h01)
    ) dut (
        .i_clk        (clk),
        .i_rst        (srst),
        .i_irq        (irq),
        .i_mask_we    (mask_we),
        .i_mask_wdata (mask_wdata),
        .o_mask       (mask),
        .o_pending    (pending),
        .o_irq_req    (irq_req),
        .o_irq_id     (irq_id),
        .o_trap_vec   (trap_vec),
        .i_irq_ack    (irq_ack),
        .i_irq_done   (irq_done),
        .o_busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_mask(input logic [7:0] m);
        mask_we    = 1'b1;
        mask_wdata = m;
        tick();
        mask_we    = 1'b0;
    endtask

    task automatic pulse_ack();
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
    endtask

    task automatic pulse_done();
        irq_done = 1'b1;
        tick();
        irq_done = 1'b0;
    endtask

    task automatic push_exp(input logic [2:0] id, input logic [31:0] vec);
        exp_t e;
        e.id  = id;
        e.vec = vec;
        sb_q.push_back(e);
    endtask

    // Scoreboard side: every new request must match the oldest queued expectation
    always @(negedge clk) begin
        if (srst) begin
            req_prev <= 1'b0;
        end else begin
            if (irq_req && !req_prev) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_req_id", {29'd0, irq_id}, 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    $display("req: id=%0d vec=0x%08h (expected id=%0d vec=0x%08h)",
                             irq_id, trap_vec, e.id, e.vec);
                    check("req_id", {29'd0, irq_id}, {29'd0, e.id});
                    check("req_vec", trap_vec, e.vec);
                end
            end
            req_prev <= irq_req;
        end
    end

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        srst       = 1'b1;
        irq        = 8'h00;
        mask_we    = 1'b0;
        mask_wdata = 8'h00;
        irq_ack    = 1'b0;
        irq_done   = 1'b0;
        tick();
        tick();
        srst = 1'b0;
        tick();
        check("rst_mask", {24'd0, mask}, 32'h0);
        check("rst_pending", {24'd0, pending}, 32'h0);
        check("rst_req", {31'd0, irq_req}, 32'h0);
        check("rst_id", {29'd0, irq_id}, 32'h0);
        check("rst_busy", {31'd0, busy}, 32'h0);

        // 1: single edge source 3
        write_mask(8'hFF);
        check("t1_mask", {24'd0, mask}, 32'hFF);
        push_exp(3'd3, 32'h10C);
        irq = 8'h08;
        tick();
        irq = 8'h00;
        check("t1_pending", {24'd0, pending}, 32'h08);
        check("t1_req_early", {31'd0, irq_req}, 32'h0);
        tick();
        check("t1_req", {31'd0, irq_req}, 32'h1);
        pulse_ack();
        check("t1_pending_ack", {24'd0, pending}, 32'h0);
        check("t1_busy", {31'd0, busy}, 32'h1);
        check("t1_req_active", {31'd0, irq_req}, 32'h0);
        pulse_done();
        check("t1_busy_done", {31'd0, busy}, 32'h0);

        // 2: simultaneous sources 5 and 2, highest index first
        push_exp(3'd5, 32'h114);
        push_exp(3'd2, 32'h108);
        irq = 8'h24;
        tick();
        irq = 8'h00;
        check("t2_pending", {24'd0, pending}, 32'h24);
        tick();
        check("t2_id5", {29'd0, irq_id}, 32'd5);
        pulse_ack();
        check("t2_pending_ack", {24'd0, pending}, 32'h04);
        pulse_ack();  // stray ack while ACTIVE is ignored
        check("t2_stray_ack_pending", {24'd0, pending}, 32'h04);
        check("t2_stray_ack_busy", {31'd0, busy}, 32'h1);
        pulse_done();
        check("t2_idle_gap", {31'd0, irq_req}, 32'h0);
        tick();
        check("t2_req2", {31'd0, irq_req}, 32'h1);
        check("t2_vec2", trap_vec, 32'h108);
        pulse_ack();
        pulse_done();

        // 3: masked source only requests after the mask is opened
        write_mask(8'h00);
        irq = 8'h80;
        tick();
        irq = 8'h00;
        tick();
        check("t3_masked_req", {31'd0, irq_req}, 32'h0);
        check("t3_pending", {24'd0, pending}, 32'h80);
        push_exp(3'd7, 32'h11C);
        write_mask(8'h80);
        check("t3_req_1cyc", {31'd0, irq_req}, 32'h0);
        tick();
        check("t3_req_2cyc", {31'd0, irq_req}, 32'h1);
        pulse_ack();
        pulse_done();

        // 4: request withdrawn by masking it off
        write_mask(8'hFF);
        push_exp(3'd4, 32'h110);
        irq = 8'h10;
        tick();
        irq = 8'h00;
        tick();
        check("t4_req", {31'd0, irq_req}, 32'h1);
        write_mask(8'h00);
        check("t4_req_hold", {31'd0, irq_req}, 32'h1);
        tick();
        check("t4_req_drop", {31'd0, irq_req}, 32'h0);
        check("t4_busy", {31'd0, busy}, 32'h0);
        check("t4_pending", {24'd0, pending}, 32'h10);

        // 5: level source 0 is re-requested while held, silent once dropped
        write_mask(8'h01);
        push_exp(3'd0, 32'h100);
        push_exp(3'd0, 32'h100);
        irq = 8'h01;
        tick();
        tick();
        check("t5_req", {31'd0, irq_req}, 32'h1);
        pulse_ack();
        check("t5_pending_level", {24'd0, pending}, 32'h11);
        pulse_done();
        tick();
        check("t5_rereq", {31'd0, irq_req}, 32'h1);
        check("t5_rereq_id", {29'd0, irq_id}, 32'd0);
        pulse_ack();
        irq = 8'h00;
        pulse_done();
        tick();
        tick();
        check("t5_no_req", {31'd0, irq_req}, 32'h0);
        check("t5_pending_drop", {24'd0, pending}, 32'h10);

        // 6: reset in the middle of an active interrupt
        srst = 1'b1;
        tick();
        srst = 1'b0;
        check("t6_pre_pending", {24'd0, pending}, 32'h0);
        write_mask(8'hFF);
        push_exp(3'd5, 32'h114);
        irq = 8'h20;
        tick();
        irq = 8'h00;
        tick();
        pulse_ack();
        irq = 8'h30;
        tick();
        irq = 8'h00;
        check("t6_pending", {24'd0, pending}, 32'h30);
        check("t6_busy", {31'd0, busy}, 32'h1);
        srst = 1'b1;
        tick();
        srst = 1'b0;
        check("t6_rst_pending", {24'd0, pending}, 32'h0);
        check("t6_rst_mask", {24'd0, mask}, 32'h0);
        check("t6_rst_req", {31'd0, irq_req}, 32'h0);
        check("t6_rst_id", {29'd0, irq_id}, 32'h0);
        check("t6_rst_busy", {31'd0, busy}, 32'h0);
        check("t6_rst_vec", trap_vec, 32'h100);
        pulse_done();
        check("t6_done_ignored_busy", {31'd0, busy}, 32'h0);
        tick();
        check("t6_done_ignored_req", {31'd0, irq_req}, 32'h0);

        tick();
        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
